// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the adder-sharing sequencer.
// State encoding, datapath width and requester limit.
package adder_share_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/adder32.sv
// Existing 32-bit ripple-carry adder shared across the datapath.
// Carry chain is evaluated bit by bit from carryIn upward.
module adder32 (
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic        carryIn,
    output logic [31:0] sum,
    output logic        carry
);

    logic [32:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = carryIn;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = input1[i] ^ input2[i] ^ c[i];
            c[i+1]   = (input1[i] & input2[i]) |
                       (c[i] & (input1[i] ^ input2[i]));
        end
    end

    assign carry = c[32];

endmodule

// File: rtl/adder_share_arbiter_rr_picker.sv
// Combinational round-robin selector: first eligible requester at or
// after ptr, wrapping to the lowest index when none is found above it.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [NUM_REQ-1:0] elig;

    assign elig = req & ~mask;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && elig[j] && (ID_W'(j) >= ptr)) begin
                valid     = 1'b1;
                idx       = ID_W'(j);
                onehot[j] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && elig[j]) begin
                valid     = 1'b1;
                idx       = ID_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one 32-bit adder among NUM_REQ requesters, round-robin,
// with registered operands, registered results and a tagged done pulse.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DATA_W*NUM_REQ-1:0] opA,
    input  logic [DATA_W*NUM_REQ-1:0] opB,
    input  logic [NUM_REQ-1:0]        cin,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      done,
    output logic [ID_W-1:0]           doneId,
    output logic [DATA_W-1:0]         sum,
    output logic                      carry,
    output logic                      overflow
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                cin_q, cin_d;

    logic [NUM_REQ-1:0]  mask;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [DATA_W-1:0]   add_sum;
    logic                add_carry;

    // The requester just served may not win again in its own DONE cycle.
    always_comb begin
        mask = '0;
        if (state_q == DONE) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (win_q == ID_W'(j)) mask[j] = 1'b1;
            end
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req),
        .mask   (mask),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    adder32 u_add (
        .input1  (a_q),
        .input2  (b_q),
        .carryIn (cin_q),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        id_d    = id_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        unique case (state_q)
            ADD: begin
                sum_d   = add_sum;
                carry_d = add_carry;
                ovf_d   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                          (add_sum[DATA_W-1] != a_q[DATA_W-1]);
                id_d    = win_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (pick_valid) begin
                    a_d   = '0;
                    b_d   = '0;
                    cin_d = 1'b0;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (pick_oh[j]) begin
                            a_d   = opA[j*DATA_W +: DATA_W];
                            b_d   = opB[j*DATA_W +: DATA_W];
                            cin_d = cin[j];
                        end
                    end
                    win_d   = pick_idx;
                    gnt_d   = pick_oh;
                    ptr_d   = (pick_idx == ID_W'(NUM_REQ-1)) ?
                              '0 : pick_idx + ID_W'(1);
                    state_d = ADD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign doneId   = id_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with hand-computed results.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] opA;
    logic [95:0] opB;
    logic [2:0]  cin;
    logic [2:0]  gnt;
    logic        done;
    logic [2:0]  doneId;
    logic [31:0] sum;
    logic        carry;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    adder_share_arbiter #(
        .NUM_REQ (3),
        .ID_W    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .opA      (opA),
        .opB      (opB),
        .cin      (cin),
        .gnt      (gnt),
        .done     (done),
        .doneId   (doneId),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a,
                           input logic [31:0] b);
        opA[i*32 +: 32] = a;
        opB[i*32 +: 32] = b;
    endtask

    task automatic chk_done(input string tag, input logic [2:0] id,
                            input logic [31:0] s, input logic c,
                            input logic v);
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".gnt"}, 64'(gnt), 64'd0);
        check({tag, ".id"}, 64'(doneId), 64'(id));
        check({tag, ".sum"}, 64'(sum), 64'(s));
        check({tag, ".carry"}, 64'(carry), 64'(c));
        check({tag, ".ovf"}, 64'(overflow), 64'(v));
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        opA = '0;
        opB = '0;
        cin = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst.gnt", 64'(gnt), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.id", 64'(doneId), 64'd0);
        check("rst.sum", 64'(sum), 64'd0);
        check("rst.flags", 64'({carry, overflow}), 64'd0);

        // single request from 0
        set_ops(0, 32'h5, 32'h3);
        req = 3'b001;
        tick();
        check("single.gnt", 64'(gnt), 64'b001);
        check("single.nodone", 64'(done), 64'd0);
        tick();
        chk_done("single", 3'd0, 32'h8, 1'b0, 1'b0);
        req = 3'b000;
        tick();
        check("single.idle", 64'({done, gnt}), 64'd0);
        check("single.hold", 64'(sum), 64'h8);

        // carry and overflow through requester 1 (ptr=1)
        set_ops(1, 32'hAA85_5ECD, 32'h9AA5_5ECD);
        cin = 3'b000;
        req = 3'b010;
        tick();
        check("cv1.gnt", 64'(gnt), 64'b010);
        tick();
        chk_done("cv1", 3'd1, 32'h452A_BD9A, 1'b1, 1'b1);
        req = 3'b000;
        tick();

        set_ops(2, 32'h7FFF_FFFF, 32'h0);
        cin = 3'b100;
        req = 3'b100;
        tick();
        check("cv2.gnt", 64'(gnt), 64'b100);
        tick();
        chk_done("cv2", 3'd2, 32'h8000_0000, 1'b0, 1'b1);
        req = 3'b000;
        tick();

        // all three at once, ptr=0
        set_ops(0, 32'd1, 32'd2);
        set_ops(1, 32'd10, 32'd20);
        set_ops(2, 32'hFFFF_FFFF, 32'd1);
        cin = 3'b000;
        req = 3'b111;
        tick();
        check("all.g0", 64'(gnt), 64'b001);
        tick();
        chk_done("all0", 3'd0, 32'd3, 1'b0, 1'b0);
        req = 3'b110;
        tick();
        check("all.g1", 64'(gnt), 64'b010);
        check("all.nd1", 64'(done), 64'd0);
        tick();
        chk_done("all1", 3'd1, 32'd30, 1'b0, 1'b0);
        req = 3'b100;
        tick();
        check("all.g2", 64'(gnt), 64'b100);
        tick();
        chk_done("all2", 3'd2, 32'd0, 1'b1, 1'b0);
        req = 3'b000;
        tick();
        check("all.idle", 64'({done, gnt}), 64'd0);

        // fairness: ptr=0, req=101 serves 0 then 2, ptr wraps to 0
        req = 3'b101;
        tick();
        check("fair.g0", 64'(gnt), 64'b001);
        tick();
        chk_done("fair0", 3'd0, 32'd3, 1'b0, 1'b0);
        req = 3'b100;
        tick();
        check("fair.g2", 64'(gnt), 64'b100);
        tick();
        chk_done("fair2", 3'd2, 32'd0, 1'b1, 1'b0);
        req = 3'b000;
        tick();
        req = 3'b011;
        tick();
        check("wrap.g0", 64'(gnt), 64'b001);
        tick();
        check("wrap.id", 64'(doneId), 64'd0);
        req = 3'b010;
        tick();
        check("wrap.g1", 64'(gnt), 64'b010);
        tick();
        check("wrap.id1", 64'(doneId), 64'd1);
        req = 3'b000;
        tick();

        // masking: requester 1 holds req through DONE (ptr=2)
        req = 3'b010;
        tick();
        check("mask.g", 64'(gnt), 64'b010);
        tick();
        chk_done("mask", 3'd1, 32'd30, 1'b0, 1'b0);
        tick();
        check("mask.noregnt", 64'({done, gnt}), 64'd0);
        tick();
        check("mask.regnt", 64'(gnt), 64'b010);
        tick();
        check("mask.done2", 64'({done, doneId}), 64'({1'b1, 3'd1}));
        req = 3'b000;
        tick();

        // reset in ADD: ptr is 2 here
        req = 3'b010;
        tick();
        check("rmid.g", 64'(gnt), 64'b010);
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
        check("rmid.done", 64'(done), 64'd0);
        check("rmid.gnt", 64'(gnt), 64'd0);
        check("rmid.sum", 64'(sum), 64'd0);
        check("rmid.misc", 64'({carry, overflow, doneId}), 64'd0);
        tick();
        check("rmid.nodone", 64'(done), 64'd0);
        set_ops(1, 32'h1234_5678, 32'h1111_1111);
        cin = 3'b010;
        req = 3'b110;
        tick();
        check("rmid.ptr0", 64'(gnt), 64'b010);
        opA[63:32] = 32'hDEAD_BEEF;
        tick();
        chk_done("rmid", 3'd1, 32'h2345_678A, 1'b0, 1'b0);
        req = 3'b100;
        tick();
        check("rmid.g2", 64'(gnt), 64'b100);
        tick();
        check("rmid.id2", 64'(doneId), 64'd2);
        req = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
